mmult_job_parser: RTL and testbench

Parses the 32-bit control-command word stream popped from the control command FIFO into validated matrix-multiply job descriptors. Presents each descriptor to the mmult kernel launch logic over a valid/ready handshake. Sits between the control command processor's command FIFO (upstream) and the kernel start/argument registers (downstream). Malformed headers and out-of-range jobs are dropped and counted.

---
 rtl/mmult_job_parser.sv | 142 ++++++++++++++
 tb/tb_mmult_job_parser.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmult_job_parser.sv
// Turns the control command FIFO word stream into range-checked mmult job descriptors.
// Bad headers and out-of-range jobs are dropped and counted instead of being launched.
module mmult_job_parser #(
  parameter logic [15:0] MAGIC   = 16'hC0DE,
  parameter int          MAX_DIM = 4096
) (
  input  logic        axis_aclk,
  input  logic        axis_arst,
  input  logic [31:0] ctl_cmd_fifo_dout,
  input  logic        ctl_cmd_fifo_empty_n,
  output logic        ctl_cmd_fifo_rd_en,
  output logic        job_valid,
  input  logic        job_ready,
  output logic [63:0] job_a_base,
  output logic [63:0] job_b_base,
  output logic [63:0] job_c_base,
  output logic [31:0] job_a_row,
  output logic [31:0] job_a_col,
  output logic [31:0] job_b_col,
  output logic [31:0] job_work_id,
  output logic        err_vld,
  output logic [31:0] err_work_id,
  output logic [31:0] job_cnt,
  output logic [15:0] hdr_err_cnt,
  output logic [15:0] job_err_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {HDR, PAY, CHECK, OUT} state_t;

  localparam logic [3:0]  LP_OP_JOB  = 4'd1;
  localparam logic [3:0]  LP_OP_NOP  = 4'd2;
  localparam logic [31:0] LP_MAX_DIM = 32'(MAX_DIM);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [31:0] r_a_base, r_b_base, r_c_base;
  logic [31:0] r_a_row, r_a_col, r_b_col, r_work_id;
  logic        r_job_valid;
  logic        r_err_vld;
  logic [31:0] r_err_work_id;
  logic [31:0] r_job_cnt;
  logic [15:0] r_hdr_err_cnt, r_job_err_cnt;

  logic w_pop;
  logic w_magic_ok;
  logic w_dims_ok;

  function automatic logic dim_ok(input logic [31:0] d);
    return (d != 32'd0) && (d <= LP_MAX_DIM);
  endfunction

  // Reset gates the pop so nothing is consumed while the parser is being cleared.
  assign w_pop      = !axis_arst && ctl_cmd_fifo_empty_n && (r_state == HDR || r_state == PAY);
  assign w_magic_ok = (ctl_cmd_fifo_dout[31:16] == MAGIC);
  assign w_dims_ok  = dim_ok(r_a_row) && dim_ok(r_a_col) && dim_ok(r_b_col);

  always_ff @(posedge axis_aclk or posedge axis_arst) begin
    if (axis_arst) begin
      r_state       <= HDR;
      r_idx         <= 3'd0;
      r_a_base      <= 32'd0;
      r_b_base      <= 32'd0;
      r_c_base      <= 32'd0;
      r_a_row       <= 32'd0;
      r_a_col       <= 32'd0;
      r_b_col       <= 32'd0;
      r_work_id     <= 32'd0;
      r_job_valid   <= 1'b0;
      r_err_vld     <= 1'b0;
      r_err_work_id <= 32'd0;
      r_job_cnt     <= 32'd0;
      r_hdr_err_cnt <= 16'd0;
      r_job_err_cnt <= 16'd0;
    end else begin
      r_err_vld <= 1'b0;
      case (r_state)
        HDR: begin
          if (w_pop) begin
            if (w_magic_ok && ctl_cmd_fifo_dout[3:0] == LP_OP_JOB) begin
              r_state <= PAY;
              r_idx   <= 3'd0;
            end else if (!(w_magic_ok && ctl_cmd_fifo_dout[3:0] == LP_OP_NOP)) begin
              if (r_hdr_err_cnt != 16'hFFFF) r_hdr_err_cnt <= r_hdr_err_cnt + 16'd1;
            end
          end
        end
        PAY: begin
          if (w_pop) begin
            case (r_idx)
              3'd0:    r_a_base  <= ctl_cmd_fifo_dout;
              3'd1:    r_b_base  <= ctl_cmd_fifo_dout;
              3'd2:    r_c_base  <= ctl_cmd_fifo_dout;
              3'd3:    r_a_row   <= ctl_cmd_fifo_dout;
              3'd4:    r_a_col   <= ctl_cmd_fifo_dout;
              3'd5:    r_b_col   <= ctl_cmd_fifo_dout;
              default: r_work_id <= ctl_cmd_fifo_dout;
            endcase
            if (r_idx == 3'd6) r_state <= CHECK;
            else               r_idx   <= r_idx + 3'd1;
          end
        end
        CHECK: begin
          if (w_dims_ok) begin
            r_state     <= OUT;
            r_job_valid <= 1'b1;
          end else begin
            r_state       <= HDR;
            r_err_vld     <= 1'b1;
            r_err_work_id <= r_work_id;
            if (r_job_err_cnt != 16'hFFFF) r_job_err_cnt <= r_job_err_cnt + 16'd1;
          end
        end
        OUT: begin
          if (job_ready) begin
            r_state     <= HDR;
            r_job_valid <= 1'b0;
            r_job_cnt   <= r_job_cnt + 32'd1;
          end
        end
        default: r_state <= HDR;
      endcase
    end
  end

  assign ctl_cmd_fifo_rd_en = w_pop;
  assign job_valid          = r_job_valid;
  assign job_a_base         = {32'd0, r_a_base};
  assign job_b_base         = {32'd0, r_b_base};
  assign job_c_base         = {32'd0, r_c_base};
  assign job_a_row          = r_a_row;
  assign job_a_col          = r_a_col;
  assign job_b_col          = r_b_col;
  assign job_work_id        = r_work_id;
  assign err_vld            = r_err_vld;
  assign err_work_id        = r_err_work_id;
  assign job_cnt            = r_job_cnt;
  assign hdr_err_cnt        = r_hdr_err_cnt;
  assign job_err_cnt        = r_job_err_cnt;
  assign busy               = (r_state != HDR);

endmodule

// File: tb/tb_mmult_job_parser.sv
// Directed bench for mmult_job_parser: a queue-backed command FIFO model feeds
// table vectors and multi-cycle scenarios; a negedge monitor captures descriptors and errors.
module tb_mmult_job_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fifo_dout = 32'd0;
  logic        empty_n = 1'b0;
  logic        rd_en;
  logic        rdy = 1'b1;
  logic        job_valid;
  logic [63:0] a_base, b_base, c_base;
  logic [31:0] a_row, a_col, b_col, work_id;
  logic        err_vld;
  logic [31:0] err_work_id;
  logic [31:0] job_cnt;
  logic [15:0] hdr_err_cnt, job_err_cnt;
  logic        busy;

  mmult_job_parser dut (
    .axis_aclk(clk), .axis_arst(rst),
    .ctl_cmd_fifo_dout(fifo_dout), .ctl_cmd_fifo_empty_n(empty_n), .ctl_cmd_fifo_rd_en(rd_en),
    .job_valid(job_valid), .job_ready(rdy),
    .job_a_base(a_base), .job_b_base(b_base), .job_c_base(c_base),
    .job_a_row(a_row), .job_a_col(a_col), .job_b_col(b_col), .job_work_id(work_id),
    .err_vld(err_vld), .err_work_id(err_work_id),
    .job_cnt(job_cnt), .hdr_err_cnt(hdr_err_cnt), .job_err_cnt(job_err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // FIFO model: outputs change only at posedge+1, pop decision sampled at negedge
  logic [31:0] q[$];
  logic        tb_pop = 1'b0;
  logic        gap = 1'b0;
  logic        tog = 1'b0;
  int          pops = 0;

  always @(posedge clk) begin
    if (tb_pop && q.size() > 0) begin
      q.delete(0);
      pops++;
    end
    tog = ~tog;
    #1;
    fifo_dout = (q.size() > 0) ? q[0] : 32'd0;
    empty_n   = (q.size() > 0) && (!gap || tog);
  end

  typedef struct {
    logic [63:0] a_base, b_base, c_base;
    logic [31:0] a_row, a_col, b_col, work_id;
  } job_t;

  job_t        jq[$];
  logic [31:0] errq[$];
  job_t        held;
  logic        held_v = 1'b0;
  job_t        cur;

  always @(negedge clk) begin
    tb_pop = rd_en;
    cur = '{a_base, b_base, c_base, a_row, a_col, b_col, work_id};
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (err_vld) errq.push_back(err_work_id);
      if (held_v) begin
        chk("valid_held", {63'd0, job_valid}, 64'd1);
        chk("held_work_id", cur.work_id, held.work_id);
        chk("held_a_base", cur.a_base, held.a_base);
        chk("held_b_col", cur.b_col, held.b_col);
      end
      if (job_valid) begin
        chk("no_pop_while_valid", {63'd0, rd_en}, 64'd0);
        if (rdy) jq.push_back(cur);
        held   = cur;
        held_v = !rdy;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  typedef struct {
    logic [31:0] hdr;
    logic        pay;
    logic [31:0] a, b, c, r, col, bc, id;
    logic        exp_job;
    logic        exp_err;
    logic [15:0] exp_hdr;
    logic [15:0] exp_jerr;
    logic [31:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] hdr, input logic pay,
                              input logic [31:0] a, b, c, r, col, bc, id,
                              input logic ej, ee, input logic [15:0] eh, ejr,
                              input logic [31:0] ec);
    vec_t v;
    v = '{hdr, pay, a, b, c, r, col, bc, id, ej, ee, eh, ejr, ec};
    return v;
  endfunction

  task automatic push_job(input logic [31:0] hdr, input logic pay,
                          input logic [31:0] a, b, c, r, col, bc, id);
    q.push_back(hdr);
    if (pay) begin
      q.push_back(a); q.push_back(b); q.push_back(c);
      q.push_back(r); q.push_back(col); q.push_back(bc); q.push_back(id);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(q.size() == 0 && !empty_n && !busy && !job_valid) && n < budget);
    if (n >= budget) chk({name, "_timeout"}, 64'(n), 64'(budget - 1));
    repeat (2) @(posedge clk);
    #2;
  endtask

  vec_t vecs[12];
  int   p0, fv, n;

  initial begin
    vecs[0]  = mk(32'hC0DE0001, 1, 32'h1000, 32'h2000, 32'h3000, 16, 16, 16, 7,      1, 0, 0, 0, 2);
    vecs[1]  = mk(32'hDEAD0001, 0, 0, 0, 0, 0, 0, 0, 0,                             0, 0, 1, 0, 2);
    vecs[2]  = mk(32'hC0DE0005, 0, 0, 0, 0, 0, 0, 0, 0,                             0, 0, 2, 0, 2);
    vecs[3]  = mk(32'hC0DE0001, 1, 32'hA0, 32'hB0, 32'hC0, 1, 1, 1, 32'h11,        1, 0, 2, 0, 3);
    vecs[4]  = mk(32'hC0DE0001, 1, 32'h10, 32'h20, 32'h30, 8, 0, 8, 9,             0, 1, 2, 1, 3);
    vecs[5]  = mk(32'hC0DE0001, 1, 32'h10, 32'h20, 32'h30, 8, 8, 4097, 10,         0, 1, 2, 2, 3);
    vecs[6]  = mk(32'hC0DE0001, 1, 32'h4000, 32'h5000, 32'h6000, 4096, 4096, 4096, 12, 1, 0, 2, 2, 4);
    vecs[7]  = mk(32'hC0DE0002, 0, 0, 0, 0, 0, 0, 0, 0,                             0, 0, 2, 2, 4);
    vecs[8]  = mk(32'hC0DEFFF1, 1, 32'hFFFFFFFF, 32'h1, 32'h2, 3, 5, 7, 32'hABCD,  1, 0, 2, 2, 5);
    vecs[9]  = mk(32'hC0DF0001, 0, 0, 0, 0, 0, 0, 0, 0,                             0, 0, 3, 2, 5);
    vecs[10] = mk(32'hC0DE0001, 1, 32'h1, 32'h2, 32'h3, 4097, 2, 2, 32'h55,        0, 1, 3, 3, 5);
    vecs[11] = mk(32'hC0DE0000, 0, 0, 0, 0, 0, 0, 0, 0,                             0, 0, 4, 3, 5);

    #12;
    chk("rst_rd_en", {63'd0, rd_en}, 0);
    chk("rst_job_valid", {63'd0, job_valid}, 0);
    chk("rst_err_vld", {63'd0, err_vld}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_job_cnt", job_cnt, 0);
    chk("rst_a_base", a_base, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // single job: header pop edge, then valid 8 edges later, handshake at the 9th
    jq.delete();
    p0 = pops;
    push_job(32'hC0DE0001, 1, 32'h1000, 32'h2000, 32'h3000, 16, 16, 16, 7);
    n = 0;
    while (pops != p0 + 1 && n < 40) begin @(posedge clk); #2; n++; end
    chk("single_hdr_pop", 64'(pops), 64'(p0 + 1));
    fv = 0; n = 0;
    do begin
      @(posedge clk); #2;
      n++;
      if (job_valid && fv == 0) fv = n;
    end while (job_cnt != 32'd1 && n < 40);
    chk("single_valid_edge", 64'(fv), 8);
    chk("single_done_edge", 64'(n), 9);
    wait_idle("single", 40);
    chk("single_jobs", 64'(jq.size()), 1);
    if (jq.size() > 0) begin
      chk("single_a_base", jq[0].a_base, 64'h1000);
      chk("single_c_base", jq[0].c_base, 64'h3000);
      chk("single_work_id", jq[0].work_id, 7);
    end

    foreach (vecs[i]) begin
      jq.delete();
      errq.delete();
      push_job(vecs[i].hdr, vecs[i].pay, vecs[i].a, vecs[i].b, vecs[i].c,
               vecs[i].r, vecs[i].col, vecs[i].bc, vecs[i].id);
      wait_idle($sformatf("vec%0d", i), 60);
      chk($sformatf("vec%0d_jobs", i), 64'(jq.size()), 64'(vecs[i].exp_job));
      chk($sformatf("vec%0d_errs", i), 64'(errq.size()), 64'(vecs[i].exp_err));
      if (vecs[i].exp_job && jq.size() > 0) begin
        chk($sformatf("vec%0d_a_base", i), jq[0].a_base, {32'd0, vecs[i].a});
        chk($sformatf("vec%0d_b_base", i), jq[0].b_base, {32'd0, vecs[i].b});
        chk($sformatf("vec%0d_c_base", i), jq[0].c_base, {32'd0, vecs[i].c});
        chk($sformatf("vec%0d_a_row", i), jq[0].a_row, vecs[i].r);
        chk($sformatf("vec%0d_a_col", i), jq[0].a_col, vecs[i].col);
        chk($sformatf("vec%0d_b_col", i), jq[0].b_col, vecs[i].bc);
        chk($sformatf("vec%0d_work_id", i), jq[0].work_id, vecs[i].id);
      end
      if (vecs[i].exp_err && errq.size() > 0)
        chk($sformatf("vec%0d_err_work_id", i), errq[0], vecs[i].id);
      chk($sformatf("vec%0d_hdr_err_cnt", i), hdr_err_cnt, vecs[i].exp_hdr);
      chk($sformatf("vec%0d_job_err_cnt", i), job_err_cnt, vecs[i].exp_jerr);
      chk($sformatf("vec%0d_job_cnt", i), job_cnt, vecs[i].exp_cnt);
    end

    // backpressure: second queued job must stay in the FIFO until the handshake
    jq.delete();
    rdy = 1'b0;
    push_job(32'hC0DE0001, 1, 32'h1000, 32'h2000, 32'h3000, 16, 16, 16, 32'h21);
    push_job(32'hC0DE0001, 1, 32'h7000, 32'h8000, 32'h9000, 2, 2, 2, 32'h22);
    n = 0;
    while (!job_valid && n < 40) begin @(posedge clk); #2; n++; end
    chk("bp_valid_seen", {63'd0, job_valid}, 1);
    p0 = pops;
    repeat (20) begin
      @(posedge clk); #2;
      chk("bp_valid", {63'd0, job_valid}, 1);
      chk("bp_rd_en", {63'd0, rd_en}, 0);
    end
    chk("bp_no_pop", 64'(pops), 64'(p0));
    chk("bp_fifo_level", 64'(q.size()), 8);
    chk("bp_work_id", work_id, 32'h21);
    rdy = 1'b1;
    wait_idle("bp", 60);
    chk("bp_jobs", 64'(jq.size()), 2);
    if (jq.size() == 2) begin
      chk("bp_id0", jq[0].work_id, 32'h21);
      chk("bp_id1", jq[1].work_id, 32'h22);
      chk("bp_a_base1", jq[1].a_base, 64'h7000);
    end
    chk("bp_job_cnt", job_cnt, 7);

    // gapped FIFO with NOPs in between
    jq.delete();
    gap = 1'b1;
    push_job(32'hC0DE0001, 1, 32'h100, 32'h200, 32'h300, 2, 3, 4, 32'h31);
    push_job(32'hC0DE0002, 0, 0, 0, 0, 0, 0, 0, 0);
    push_job(32'hC0DE0002, 0, 0, 0, 0, 0, 0, 0, 0);
    push_job(32'hC0DE0001, 1, 32'h400, 32'h500, 32'h600, 5, 6, 7, 32'h32);
    wait_idle("gap", 120);
    gap = 1'b0;
    chk("gap_jobs", 64'(jq.size()), 2);
    if (jq.size() == 2) begin
      chk("gap_a_row0", jq[0].a_row, 2);
      chk("gap_b_col0", jq[0].b_col, 4);
      chk("gap_id0", jq[0].work_id, 32'h31);
      chk("gap_b_base1", jq[1].b_base, 64'h500);
      chk("gap_a_col1", jq[1].a_col, 6);
      chk("gap_id1", jq[1].work_id, 32'h32);
    end
    chk("gap_hdr_err_cnt", hdr_err_cnt, 4);
    chk("gap_job_cnt", job_cnt, 9);

    // reset after header + 3 payload words
    p0 = pops;
    push_job(32'hC0DE0001, 1, 32'hAAAA, 32'hBBBB, 32'hCCCC, 9, 9, 9, 32'h99);
    n = 0;
    while (pops != p0 + 4 && n < 40) begin @(posedge clk); #2; n++; end
    chk("mid_pops", 64'(pops), 64'(p0 + 4));
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 0);
    chk("mid_rst_rd_en", {63'd0, rd_en}, 0);
    chk("mid_rst_a_base", a_base, 0);
    chk("mid_rst_work_id", work_id, 0);
    chk("mid_rst_job_cnt", job_cnt, 0);
    chk("mid_rst_hdr_err", hdr_err_cnt, 0);
    chk("mid_rst_job_err", job_err_cnt, 0);
    chk("mid_rst_err_id", err_work_id, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    jq.delete();
    errq.delete();
    push_job(32'hC0DE0001, 1, 32'hD000, 32'hE000, 32'hF000, 3, 3, 3, 32'h41);
    wait_idle("post_rst", 60);
    chk("post_rst_jobs", 64'(jq.size()), 1);
    if (jq.size() == 1) begin
      chk("post_rst_a_base", jq[0].a_base, 64'hD000);
      chk("post_rst_id", jq[0].work_id, 32'h41);
    end
    chk("post_rst_errs", 64'(errq.size()), 0);
    chk("post_rst_job_cnt", job_cnt, 1);
    chk("post_rst_hdr_err", hdr_err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
